// File: rtl/oam_dma_arb.sv
// OAM DMA engine with CPU/DMA bus arbitration: copies DMA_LEN bytes from
// {src_hi,8'h00} to OAM_BASE while restricting the CPU to the HRAM window.
package sm83_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

module oam_dma_arb
  import sm83_pkg::*;
#(
  parameter addr_t DMA_REG_ADDR = 16'hFF46,
  parameter addr_t OAM_BASE     = 16'hFE00,
  parameter int    DMA_LEN      = 160,
  parameter addr_t HRAM_LO      = 16'hFF80,
  parameter addr_t HRAM_HI      = 16'hFFFE
) (
  input  logic  clk,
  input  logic  rst,
  input  addr_t cpu_addr,
  input  logic  cpu_wen,
  input  data_t cpu_wdata,
  output data_t cpu_rdata,
  output logic  cpu_wait,
  output addr_t mem_r_addr,
  output addr_t mem_w_addr,
  output logic  mem_wen,
  output data_t mem_w_data,
  input  data_t mem_r_data,
  output logic  dma_active
);

  typedef enum logic [1:0] {IDLE, START, RD, WR} state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  src_hi_q, src_hi_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  dbuf_q, dbuf_d;

  logic reg_hit;
  logic hram_hit;

  assign reg_hit    = (cpu_addr == DMA_REG_ADDR);
  assign hram_hit   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
  assign dma_active = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      src_hi_q <= 8'h00;
      idx_q    <= 8'h00;
      dbuf_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      idx_q    <= idx_d;
      dbuf_q   <= dbuf_d;
    end
  end

  // The DMA owns the read port in RD and the write port in WR; the CPU may
  // use whichever port the DMA leaves free, but only inside the HRAM window.
  always_comb begin
    state_d    = state_q;
    src_hi_d   = src_hi_q;
    idx_d      = idx_q;
    dbuf_d     = dbuf_q;
    mem_r_addr = cpu_addr;
    mem_w_addr = cpu_addr;
    mem_w_data = cpu_wdata;
    mem_wen    = 1'b0;
    cpu_rdata  = 8'hFF;
    cpu_wait   = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_wen   = cpu_wen;
        cpu_rdata = mem_r_data;
      end
      START: begin
        state_d = RD;
        if (hram_hit) begin
          mem_wen   = cpu_wen;
          cpu_rdata = mem_r_data;
        end
      end
      RD: begin
        mem_r_addr = {src_hi_q, idx_q};
        dbuf_d     = mem_r_data;
        state_d    = WR;
        if (hram_hit) begin
          if (cpu_wen) mem_wen  = 1'b1;
          else         cpu_wait = 1'b1;
        end
      end
      WR: begin
        mem_w_addr = OAM_BASE + {8'h00, idx_q};
        mem_w_data = dbuf_q;
        mem_wen    = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = RD;
        end
        if (hram_hit) begin
          if (cpu_wen) cpu_wait  = 1'b1;
          else         cpu_rdata = mem_r_data;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reg_hit) cpu_rdata = src_hi_q;
    // A trigger write overrides whatever the FSM chose, restarting any transfer.
    if (reg_hit && cpu_wen) begin
      src_hi_d = cpu_wdata;
      idx_d    = 8'h00;
      state_d  = START;
    end
  end

endmodule

// File: tb/tb_oam_dma_arb.sv
// Bench for oam_dma_arb: behavioural memory, write monitor against an
// expected-write queue, and directed DMA / arbitration / reset scenarios.
module tb_oam_dma_arb;
  import sm83_pkg::*;

  logic  clk;
  logic  rst;
  addr_t cpu_addr;
  logic  cpu_wen;
  data_t cpu_wdata;
  data_t cpu_rdata;
  logic  cpu_wait;
  addr_t mem_r_addr;
  addr_t mem_w_addr;
  logic  mem_wen;
  data_t mem_w_data;
  data_t mem_r_data;
  logic  dma_active;

  logic [7:0]  mem [0:65535];
  logic        bd_wen;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  logic [23:0] exp_q[$];
  int          total;
  int          bad;
  int          cyc_no;
  int          last_wr_cyc;
  logic        mon_en;

  oam_dma_arb dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wen    (cpu_wen),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_wait   (cpu_wait),
    .mem_r_addr (mem_r_addr),
    .mem_w_addr (mem_w_addr),
    .mem_wen    (mem_wen),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .dma_active (dma_active)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  // memory model: combinational read, posedge write, plus a backdoor port
  assign mem_r_data = mem[mem_r_addr];
  always @(posedge clk) begin
    if (mem_wen === 1'b1) mem[mem_w_addr] <= mem_w_data;
    if (bd_wen) mem[bd_addr] <= bd_data;
  end

  // scoreboard: every memory write must match the head of exp_q
  always @(negedge clk) begin
    logic        have;
    logic [23:0] exp_w;
    logic [23:0] got_w;
    if (mon_en && mem_wen === 1'b1) begin
      last_wr_cyc = cyc_no;
      have  = (exp_q.size() > 0);
      exp_w = have ? exp_q.pop_front() : 24'h0;
      got_w = {mem_w_addr, mem_w_data};
      total++;
      assert (have && got_w === exp_w) else begin
        bad++;
        $error("FAIL mem_write got=%06h exp=%06h (queued=%0d)", got_w, exp_w, have);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cpu_addr  = 16'h0000;
    cpu_wen   = 1'b0;
    cpu_wdata = 8'h00;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_wen  = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge clk);
    #1;
    bd_wen  = 1'b0;
  endtask

  function automatic logic [7:0] d_pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    int trig_cyc;
    int act_cnt;
    int errs;

    total = 0; bad = 0; mon_en = 1'b0; last_wr_cyc = 0;
    rst = 1'b1; cpu_addr = 16'h0000; cpu_wen = 1'b0; cpu_wdata = 8'h00;
    bd_wen = 1'b0; bd_addr = 16'h0000; bd_data = 8'h00;

    // preload through the backdoor while reset is held
    for (int i = 0; i < 160; i++) begin
      bd_write(16'hC000 + 16'(i), 8'(i));
      bd_write(16'hD000 + 16'(i), d_pat(i));
    end
    bd_write(16'hFF81, 8'h77);
    rst = 1'b0;
    cpu_addr = 16'hFF46;
    @(negedge clk);
    chk("rst_active", 32'(dma_active), 32'h0);
    chk("rst_wait", 32'(cpu_wait), 32'h0);
    chk("rst_srchi", 32'(cpu_rdata), 32'h00);
    mon_en = 1'b1;

    // IDLE pass-through
    step();
    cpu_addr = 16'hC123; cpu_wen = 1'b1; cpu_wdata = 8'h3C;
    exp_q.push_back({16'hC123, 8'h3C});
    @(negedge clk);
    chk("idle_wr_wait", 32'(cpu_wait), 32'h0);
    chk("idle_wr_wen", 32'(mem_wen), 32'h1);
    step();
    cpu_addr = 16'hC123;
    @(negedge clk);
    chk("idle_rd_data", 32'(cpu_rdata), 32'h3C);
    chk("idle_rd_wait", 32'(cpu_wait), 32'h0);
    step();
    cpu_addr = 16'hC005;
    @(negedge clk);
    chk("idle_rd_c005", 32'(cpu_rdata), 32'h05);

    // full transfer from C000 with CPU arbitration probes
    step();
    cpu_addr = 16'hFF46; cpu_wen = 1'b1; cpu_wdata = 8'hC0;
    exp_q.push_back({16'hFF46, 8'hC0});
    trig_cyc = cyc_no;
    @(negedge clk);
    chk("trig_active", 32'(dma_active), 32'h0);
    act_cnt = 0;
    for (int k = 1; k < 400; k++) begin
      step();
      case (k)
        10: cpu_addr = 16'h0150;
        11: begin cpu_addr = 16'hC000; cpu_wen = 1'b1; cpu_wdata = 8'h55; end
        12: begin
          cpu_addr = 16'hFF80; cpu_wen = 1'b1; cpu_wdata = 8'hA5;
          exp_q.push_back({16'hFF80, 8'hA5});
        end
        14, 15: cpu_addr = 16'hFF80;
        17: begin cpu_addr = 16'hFF81; cpu_wen = 1'b1; cpu_wdata = 8'h11; end
        20: cpu_addr = 16'hFF46;
        default: ;
      endcase
      if (k >= 2 && k <= 320 && (k % 2) == 0)
        exp_q.push_back({16'hFE00 + 16'((k - 2) / 2), 8'((k - 2) / 2)});
      @(negedge clk);
      case (k)
        1:  chk("start_active", 32'(dma_active), 32'h1);
        2:  chk("rd0_addr", 32'(mem_r_addr), 32'hC000);
        10: begin
          chk("blk_rd_data", 32'(cpu_rdata), 32'hFF);
          chk("blk_rd_wait", 32'(cpu_wait), 32'h0);
        end
        11: chk("blk_wr_wait", 32'(cpu_wait), 32'h0);
        12: chk("hram_wr_rd_wait", 32'(cpu_wait), 32'h0);
        14: chk("hram_rd_in_rd_wait", 32'(cpu_wait), 32'h1);
        15: begin
          chk("hram_rd_in_wr_data", 32'(cpu_rdata), 32'hA5);
          chk("hram_rd_in_wr_wait", 32'(cpu_wait), 32'h0);
        end
        17: chk("hram_wr_in_wr_wait", 32'(cpu_wait), 32'h1);
        20: chk("srchi_active", 32'(cpu_rdata), 32'hC0);
        default: ;
      endcase
      if (dma_active) act_cnt++;
      else break;
    end
    chk("active_cycles", 32'(act_cnt), 32'd321);
    chk("last_wr_cycle", 32'(last_wr_cyc - trig_cyc), 32'd321);
    chk("dma1_queue_empty", 32'(exp_q.size()), 32'd0);
    errs = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== 8'(i)) errs++;
    chk("oam_from_c000", 32'(errs), 32'd0);
    chk("c000_unchanged", 32'(mem[16'hC000]), 32'h00);
    chk("ff80_written", 32'(mem[16'hFF80]), 32'hA5);
    chk("ff81_unchanged", 32'(mem[16'hFF81]), 32'h77);

    // restart at idx=50 with a new source page
    step();
    cpu_addr = 16'hFF46; cpu_wen = 1'b1; cpu_wdata = 8'hC0;
    exp_q.push_back({16'hFF46, 8'hC0});
    @(negedge clk);
    act_cnt = 0;
    trig_cyc = 0;
    for (int k = 1; k < 600; k++) begin
      step();
      if (k >= 2 && k <= 100 && (k % 2) == 0)
        exp_q.push_back({16'hFE00 + 16'((k - 2) / 2), 8'((k - 2) / 2)});
      if (k == 102) begin
        cpu_addr = 16'hFF46; cpu_wen = 1'b1; cpu_wdata = 8'hD0;
        trig_cyc = cyc_no;
        for (int i = 0; i < 160; i++)
          exp_q.push_back({16'hFE00 + 16'(i), d_pat(i)});
      end
      @(negedge clk);
      case (k)
        102: chk("rst_trig_rd_addr", 32'(mem_r_addr), 32'hC032);
        103: chk("restart_active", 32'(dma_active), 32'h1);
        104: chk("restart_rd0", 32'(mem_r_addr), 32'hD000);
        106: chk("restart_rd1", 32'(mem_r_addr), 32'hD001);
        default: ;
      endcase
      if (dma_active) act_cnt++;
      else break;
    end
    chk("restart_active_cycles", 32'(act_cnt), 32'd423);
    chk("restart_last_wr", 32'(last_wr_cyc - trig_cyc), 32'd321);
    chk("dma2_queue_empty", 32'(exp_q.size()), 32'd0);
    errs = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== d_pat(i)) errs++;
    chk("oam_from_d000", 32'(errs), 32'd0);
    step();
    cpu_addr = 16'hFF46;
    @(negedge clk);
    chk("srchi_d0", 32'(cpu_rdata), 32'hD0);

    // reset in the middle of a transfer at idx=80
    for (int i = 0; i < 160; i++) bd_write(16'hFE00 + 16'(i), 8'hEE);
    step();
    cpu_addr = 16'hFF46; cpu_wen = 1'b1; cpu_wdata = 8'hC0;
    exp_q.push_back({16'hFF46, 8'hC0});
    @(negedge clk);
    for (int k = 1; k <= 162; k++) begin
      step();
      if (k >= 2 && k <= 160 && (k % 2) == 0)
        exp_q.push_back({16'hFE00 + 16'((k - 2) / 2), 8'((k - 2) / 2)});
      if (k == 162) rst = 1'b1;
      @(negedge clk);
      if (k == 162) chk("rd80_addr", 32'(mem_r_addr), 32'hC050);
    end
    step();
    rst = 1'b0;
    cpu_addr = 16'hFF46;
    @(negedge clk);
    chk("post_rst_active", 32'(dma_active), 32'h0);
    chk("post_rst_wait", 32'(cpu_wait), 32'h0);
    chk("post_rst_srchi", 32'(cpu_rdata), 32'h00);
    for (int k = 0; k < 340; k++) step();
    chk("dma3_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("fe4f_written", 32'(mem[16'hFE4F]), 32'h4F);
    chk("fe50_untouched", 32'(mem[16'hFE50]), 32'hEE);
    chk("fe9f_untouched", 32'(mem[16'hFE9F]), 32'hEE);
    step();
    cpu_addr = 16'hC200; cpu_wen = 1'b1; cpu_wdata = 8'h12;
    exp_q.push_back({16'hC200, 8'h12});
    @(negedge clk);
    chk("post_rst_wr_wait", 32'(cpu_wait), 32'h0);
    step();
    cpu_addr = 16'hC200;
    @(negedge clk);
    chk("post_rst_rd", 32'(cpu_rdata), 32'h12);
    step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
